ace_rd_responder: RTL and testbench

- ACE read-side subordinate model. Sits at the far end of the IFU's ACE read path in unit-level benches and small SoC sims.
- Accepts AR requests, returns R bursts from an internal word array, and consumes RACK.
- Drives the snoop channels idle; the write path is out of scope.
- Preload port fills memory before or between bursts.

---
 rtl/ace_rd_responder.sv | 239 +++++++++++++++++++++++
 tb/tb_ace_rd_responder.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ace_rd_responder.sv
// ace_rd_responder
//   ACE read-side subordinate model. Accepts one AR request at a time, returns
//   an R burst from an internal word array, then waits for RACK before the next
//   request. Snoop channels are tied idle; there is no write channel.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   ace_ar*           read address channel (id, addr, len, size, burst, valid/ready)
//   ace_r*            read data channel (id, data, resp, last, valid/ready)
//   ace_rack          read acknowledge pulse, legal only after the last R beat
//   ace_acvalid       snoop address valid, tied 0
//   ace_crready       snoop response ready, tied 1
//   ace_cdready       snoop data ready, tied 1
//   mem_we/waddr/wdata preload port, synchronous word write in any state
//   busy              high whenever the FSM is not idle
//   protocol_err      sticky flag: RACK seen outside the acknowledge phase
module ace_rd_responder #(
  parameter int unsigned ACE_XID_WIDTH     = 4,
  parameter int unsigned ACE_AXADDR_WIDTH  = 32,
  parameter int unsigned ACE_AXLEN_WIDTH   = 8,
  parameter int unsigned ACE_AXSIZE_WIDTH  = 3,
  parameter int unsigned ACE_AXBURST_WIDTH = 2,
  parameter int unsigned ACE_XDATA_WIDTH   = 32,
  parameter int unsigned ACE_RRESP_WIDTH   = 2,
  parameter int unsigned DEPTH             = 1024,
  parameter logic [ACE_AXADDR_WIDTH-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned LATENCY           = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ACE_XID_WIDTH-1:0]      ace_arid,
  input  logic [ACE_AXADDR_WIDTH-1:0]   ace_araddr,
  input  logic [ACE_AXLEN_WIDTH-1:0]    ace_arlen,
  input  logic [ACE_AXSIZE_WIDTH-1:0]   ace_arsize,
  input  logic [ACE_AXBURST_WIDTH-1:0]  ace_arburst,
  input  logic                          ace_arvalid,
  output logic                          ace_arready,
  output logic [ACE_XID_WIDTH-1:0]      ace_rid,
  output logic [ACE_XDATA_WIDTH-1:0]    ace_rdata,
  output logic [ACE_RRESP_WIDTH-1:0]    ace_rresp,
  output logic                          ace_rlast,
  output logic                          ace_rvalid,
  input  logic                          ace_rready,
  input  logic                          ace_rack,
  output logic                          ace_acvalid,
  output logic                          ace_crready,
  output logic                          ace_cdready,
  input  logic                          mem_we,
  input  logic [$clog2(DEPTH)-1:0]      mem_waddr,
  input  logic [ACE_XDATA_WIDTH-1:0]    mem_wdata,
  output logic                          busy,
  output logic                          protocol_err
);

  localparam int unsigned AW         = ACE_AXADDR_WIDTH;
  localparam int unsigned LW         = ACE_AXLEN_WIDTH;
  localparam int unsigned BW         = ACE_AXBURST_WIDTH;
  localparam int unsigned RW         = ACE_RRESP_WIDTH;
  localparam int unsigned BYTE_SHIFT = $clog2(ACE_XDATA_WIDTH / 8);
  localparam int unsigned IDXW       = $clog2(DEPTH);
  localparam int unsigned CW         = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [RW-1:0] RESP_OKAY   = '0;
  localparam logic [RW-1:0] RESP_SLVERR = RW'(2);

  localparam logic [BW-1:0] BURST_FIXED = BW'(0);
  localparam logic [BW-1:0] BURST_WRAP  = BW'(2);
  localparam logic [BW-1:0] BURST_RSVD  = BW'(3);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_BURST,
    S_ACK
  } state_t;

  state_t state;

  // Captured request
  logic [ACE_XID_WIDTH-1:0]    id_q;
  logic [AW-1:0]               addr_q;
  logic [LW-1:0]               len_q;
  logic [ACE_AXSIZE_WIDTH-1:0] size_q;
  logic [BW-1:0]               burst_q;
  logic                        err_all_q;   // whole-burst SLVERR
  logic [LW-1:0]               beat_q;
  logic [CW-1:0]               cnt_q;

  // Word storage (not reset)
  logic [ACE_XDATA_WIDTH-1:0]  mem [DEPTH];

  // Address sequencing and beat fetch
  logic [AW-1:0]               step;
  logic [AW-1:0]               wrap_mask;
  logic [AW-1:0]               next_addr;
  logic [AW-1:0]               fetch_addr;
  logic [AW-1:0]               offset;
  logic [AW-1:0]               word_idx;
  logic                        fetch_err;
  logic [ACE_XDATA_WIDTH-1:0]  fetch_data;
  logic                        r_hs;
  logic                        ar_hs;
  logic                        ar_err;
  logic                        wrap_len_ok;

  assign ace_acvalid = 1'b0;
  assign ace_crready = 1'b1;
  assign ace_cdready = 1'b1;
  assign busy        = (state != S_IDLE);

  assign r_hs  = ace_rvalid && ace_rready;
  assign ar_hs = ace_arvalid && ace_arready;

  // Request-wide error conditions, evaluated on the incoming AR fields.
  always_comb begin
    wrap_len_ok = (ace_arlen == LW'(1)) || (ace_arlen == LW'(3)) ||
                  (ace_arlen == LW'(7)) || (ace_arlen == LW'(15));
    ar_err      = (32'(ace_arsize) > BYTE_SHIFT) ||
                  (ace_arburst == BURST_RSVD) ||
                  ((ace_arburst == BURST_WRAP) && !wrap_len_ok);
  end

  // The data register is loaded one beat ahead: on entry to BURST it takes the
  // beat at addr_q, and on every R handshake it takes the beat at next_addr, so
  // the array read is combinational on whichever address the next beat uses.
  always_comb begin
    step      = AW'(1) << size_q;
    wrap_mask = ((AW'(len_q) + AW'(1)) << size_q) - AW'(1);
    case (burst_q)
      BURST_FIXED: next_addr = addr_q;
      BURST_WRAP:  next_addr = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
      default:     next_addr = addr_q + step;
    endcase
    fetch_addr = (state == S_BURST) ? next_addr : addr_q;
    offset     = fetch_addr - BASE_ADDR;
    word_idx   = offset >> BYTE_SHIFT;
    fetch_err  = err_all_q || (fetch_addr < BASE_ADDR) || (word_idx >= AW'(DEPTH));
    fetch_data = '0;
    if (!fetch_err) begin
      fetch_data = mem[word_idx[IDXW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && (32'(mem_waddr) < DEPTH)) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      ace_arready  <= 1'b0;
      ace_rvalid   <= 1'b0;
      ace_rlast    <= 1'b0;
      ace_rid      <= '0;
      ace_rdata    <= '0;
      ace_rresp    <= '0;
      protocol_err <= 1'b0;
      id_q         <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      err_all_q    <= 1'b0;
      beat_q       <= '0;
      cnt_q        <= '0;
    end else begin
      if (ace_rack && (state != S_ACK)) begin
        protocol_err <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          ace_arready <= 1'b1;
          if (ar_hs) begin
            ace_arready <= 1'b0;
            id_q        <= ace_arid;
            addr_q      <= ace_araddr;
            len_q       <= ace_arlen;
            size_q      <= ace_arsize;
            burst_q     <= ace_arburst;
            err_all_q   <= ar_err;
            cnt_q       <= CW'(LATENCY - 1);
            state       <= S_WAIT;
          end
        end

        S_WAIT: begin
          ace_arready <= 1'b0;
          if (cnt_q == '0) begin
            ace_rvalid <= 1'b1;
            ace_rid    <= id_q;
            ace_rdata  <= fetch_data;
            ace_rresp  <= fetch_err ? RESP_SLVERR : RESP_OKAY;
            ace_rlast  <= (len_q == '0);
            beat_q     <= '0;
            state      <= S_BURST;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end

        S_BURST: begin
          ace_arready <= 1'b0;
          if (r_hs) begin
            if (ace_rlast) begin
              ace_rvalid <= 1'b0;
              ace_rlast  <= 1'b0;
              state      <= S_ACK;
            end else begin
              addr_q     <= next_addr;
              beat_q     <= beat_q + LW'(1);
              ace_rdata  <= fetch_data;
              ace_rresp  <= fetch_err ? RESP_SLVERR : RESP_OKAY;
              ace_rlast  <= ((beat_q + LW'(1)) == len_q);
            end
          end
        end

        S_ACK: begin
          ace_arready <= 1'b0;
          if (ace_rack) begin
            ace_arready <= 1'b1;
            state       <= S_IDLE;
          end
        end

        default: begin
          state       <= S_IDLE;
          ace_arready <= 1'b0;
          ace_rvalid  <= 1'b0;
          ace_rlast   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ace_rd_responder.sv
// tb_ace_rd_responder
//   Directed bench for ace_rd_responder: INCR, WRAP, FIXED, stall, out-of-range,
//   request-wide errors, delayed RACK, spurious RACK and reset mid-burst.
module tb_ace_rd_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk;
  logic        rst_n;
  logic [3:0]  ace_arid;
  logic [31:0] ace_araddr;
  logic [7:0]  ace_arlen;
  logic [2:0]  ace_arsize;
  logic [1:0]  ace_arburst;
  logic        ace_arvalid;
  logic        ace_arready;
  logic [3:0]  ace_rid;
  logic [31:0] ace_rdata;
  logic [1:0]  ace_rresp;
  logic        ace_rlast;
  logic        ace_rvalid;
  logic        ace_rready;
  logic        ace_rack;
  logic        ace_acvalid;
  logic        ace_crready;
  logic        ace_cdready;
  logic        mem_we;
  logic [5:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        protocol_err;

  int unsigned total;
  int unsigned passed;
  int unsigned failed;
  int unsigned hs_count;

  ace_rd_responder #(
    .ACE_XID_WIDTH    (4),
    .ACE_AXADDR_WIDTH (32),
    .ACE_AXLEN_WIDTH  (8),
    .ACE_AXSIZE_WIDTH (3),
    .ACE_AXBURST_WIDTH(2),
    .ACE_XDATA_WIDTH  (32),
    .ACE_RRESP_WIDTH  (2),
    .DEPTH            (64),
    .BASE_ADDR        (32'h8000_0000),
    .LATENCY          (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ace_arid    (ace_arid),
    .ace_araddr  (ace_araddr),
    .ace_arlen   (ace_arlen),
    .ace_arsize  (ace_arsize),
    .ace_arburst (ace_arburst),
    .ace_arvalid (ace_arvalid),
    .ace_arready (ace_arready),
    .ace_rid     (ace_rid),
    .ace_rdata   (ace_rdata),
    .ace_rresp   (ace_rresp),
    .ace_rlast   (ace_rlast),
    .ace_rvalid  (ace_rvalid),
    .ace_rready  (ace_rready),
    .ace_rack    (ace_rack),
    .ace_acvalid (ace_acvalid),
    .ace_crready (ace_crready),
    .ace_cdready (ace_cdready),
    .mem_we      (mem_we),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .busy        (busy),
    .protocol_err(protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after
  // the rising edge. R handshakes are counted at the edge they complete on.
  task automatic tick();
    if (ace_rvalid && ace_rready) hs_count++;
    @(posedge clk);
    #1;
  endtask

  task automatic ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                    input logic [2:0] size, input logic [1:0] burst);
    int unsigned n;
    n = 0;
    ace_arid    = id;
    ace_araddr  = addr;
    ace_arlen   = len;
    ace_arsize  = size;
    ace_arburst = burst;
    ace_arvalid = 1'b1;
    while (!ace_arready && n < 20) begin
      tick();
      n++;
    end
    chk("ar_ready_before_handshake", ace_arready, 1'b1);
    tick();
    ace_arvalid = 1'b0;
  endtask

  task automatic beat(input string tag, input logic [31:0] data, input logic [1:0] resp,
                      input logic last, input logic [3:0] id);
    chk({tag, "_rvalid"}, ace_rvalid, 1'b1);
    chk({tag, "_rdata"},  ace_rdata,  data);
    chk({tag, "_rresp"},  ace_rresp,  resp);
    chk({tag, "_rlast"},  ace_rlast,  last);
    chk({tag, "_rid"},    ace_rid,    id);
  endtask

  task automatic do_rack();
    ace_rack = 1'b1;
    tick();
    ace_rack = 1'b0;
    chk("rack_arready", ace_arready, 1'b1);
    chk("rack_busy", busy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pre_data [5];
    logic [5:0]  pre_addr [5];
    total = 0; passed = 0; failed = 0; hs_count = 0;
    rst_n = 1'b0;
    ace_arid = '0; ace_araddr = '0; ace_arlen = '0; ace_arsize = '0; ace_arburst = '0;
    ace_arvalid = 1'b0; ace_rready = 1'b0; ace_rack = 1'b0;
    mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
    pre_addr = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd63};
    pre_data = '{32'h11, 32'h22, 32'h33, 32'h44, 32'hAA};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_arready", ace_arready, 1'b0);
    chk("rst_rvalid", ace_rvalid, 1'b0);
    chk("rst_rlast", ace_rlast, 1'b0);
    chk("rst_rdata", ace_rdata, 32'h0);
    chk("rst_rresp", ace_rresp, 2'd0);
    chk("rst_rid", ace_rid, 4'd0);
    chk("rst_protocol_err", protocol_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("tie_acvalid", ace_acvalid, 1'b0);
    chk("tie_crready", ace_crready, 1'b1);
    chk("tie_cdready", ace_cdready, 1'b1);
    rst_n = 1'b1;
    tick();
    chk("idle_arready", ace_arready, 1'b1);

    // Preload
    for (int i = 0; i < 5; i++) begin
      mem_we = 1'b1; mem_waddr = pre_addr[i]; mem_wdata = pre_data[i];
      tick();
    end
    mem_we = 1'b0;

    // INCR len=3: first RVALID two edges after the AR handshake edge
    ace_rready = 1'b1;
    hs_count = 0;
    ar(4'd1, BASE, 8'd3, 3'd2, 2'd1);
    chk("incr_lat0_rvalid", ace_rvalid, 1'b0);
    chk("incr_lat0_busy", busy, 1'b1);
    chk("incr_lat0_arready", ace_arready, 1'b0);
    tick();
    chk("incr_lat1_rvalid", ace_rvalid, 1'b0);
    tick();
    beat("incr_b0", 32'h11, 2'd0, 1'b0, 4'd1);
    tick();
    beat("incr_b1", 32'h22, 2'd0, 1'b0, 4'd1);
    tick();
    beat("incr_b2", 32'h33, 2'd0, 1'b0, 4'd1);
    tick();
    beat("incr_b3", 32'h44, 2'd0, 1'b1, 4'd1);
    tick();
    chk("incr_done_rvalid", ace_rvalid, 1'b0);
    chk("incr_done_busy", busy, 1'b1);
    chk("incr_handshakes", hs_count, 4);
    do_rack();
    chk("incr_protocol_err", protocol_err, 1'b0);

    // WRAP len=3 starting at word 2
    ar(4'd2, BASE + 32'd8, 8'd3, 3'd2, 2'd2);
    tick(); tick();
    beat("wrap_b0", 32'h33, 2'd0, 1'b0, 4'd2);
    tick();
    beat("wrap_b1", 32'h44, 2'd0, 1'b0, 4'd2);
    tick();
    beat("wrap_b2", 32'h11, 2'd0, 1'b0, 4'd2);
    tick();
    beat("wrap_b3", 32'h22, 2'd0, 1'b1, 4'd2);
    tick();
    chk("wrap_done_rvalid", ace_rvalid, 1'b0);
    do_rack();

    // rready 1,0,0,1 across an INCR len=1 burst
    hs_count = 0;
    ar(4'd3, BASE, 8'd1, 3'd2, 2'd1);
    tick(); tick();
    beat("stall_b0", 32'h11, 2'd0, 1'b0, 4'd3);
    tick();
    beat("stall_b1", 32'h22, 2'd0, 1'b1, 4'd3);
    ace_rready = 1'b0;
    tick();
    beat("stall_hold1", 32'h22, 2'd0, 1'b1, 4'd3);
    tick();
    beat("stall_hold2", 32'h22, 2'd0, 1'b1, 4'd3);
    ace_rready = 1'b1;
    tick();
    chk("stall_done_rvalid", ace_rvalid, 1'b0);
    chk("stall_handshakes", hs_count, 2);
    do_rack();

    // Crossing the top of the array: second beat is out of range
    ar(4'd4, BASE + 32'd252, 8'd1, 3'd2, 2'd1);
    tick(); tick();
    beat("oob_b0", 32'hAA, 2'd0, 1'b0, 4'd4);
    tick();
    beat("oob_b1", 32'h0, 2'd2, 1'b1, 4'd4);
    tick();
    chk("oob_done_rvalid", ace_rvalid, 1'b0);

    // RACK withheld for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("ackwait_arready", ace_arready, 1'b0);
      chk("ackwait_busy", busy, 1'b1);
    end
    do_rack();

    // Oversized beat: SLVERR, data forced to 0
    ar(4'd5, BASE, 8'd0, 3'd3, 2'd1);
    tick(); tick();
    beat("size_err_b0", 32'h0, 2'd2, 1'b1, 4'd5);
    tick();
    do_rack();

    // FIXED len=1 at word 1
    ar(4'd6, BASE + 32'd4, 8'd1, 3'd2, 2'd0);
    tick(); tick();
    beat("fixed_b0", 32'h22, 2'd0, 1'b0, 4'd6);
    tick();
    beat("fixed_b1", 32'h22, 2'd0, 1'b1, 4'd6);
    tick();
    do_rack();

    // WRAP with illegal len=2: all three beats SLVERR
    ar(4'd7, BASE, 8'd2, 3'd2, 2'd2);
    tick(); tick();
    beat("wrapbad_b0", 32'h0, 2'd2, 1'b0, 4'd7);
    tick();
    beat("wrapbad_b1", 32'h0, 2'd2, 1'b0, 4'd7);
    tick();
    beat("wrapbad_b2", 32'h0, 2'd2, 1'b1, 4'd7);
    tick();
    do_rack();

    // Reserved burst type
    ar(4'd8, BASE, 8'd0, 3'd2, 2'd3);
    tick(); tick();
    beat("rsvd_b0", 32'h0, 2'd2, 1'b1, 4'd8);
    tick();
    do_rack();
    chk("pre_spurious_protocol_err", protocol_err, 1'b0);

    // Spurious RACK in IDLE
    ace_rack = 1'b1;
    tick();
    ace_rack = 1'b0;
    chk("spurious_protocol_err", protocol_err, 1'b1);
    tick(); tick();
    chk("sticky_protocol_err", protocol_err, 1'b1);

    // Reset asserted mid-burst
    ar(4'd9, BASE, 8'd3, 3'd2, 2'd1);
    tick(); tick();
    beat("midrst_b0", 32'h11, 2'd0, 1'b0, 4'd9);
    rst_n = 1'b0;
    #1;
    chk("midrst_rvalid", ace_rvalid, 1'b0);
    chk("midrst_rlast", ace_rlast, 1'b0);
    chk("midrst_rdata", ace_rdata, 32'h0);
    chk("midrst_protocol_err", protocol_err, 1'b0);
    chk("midrst_arready", ace_arready, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("postrst_arready", ace_arready, 1'b1);

    // Array contents survive reset
    ar(4'd10, BASE + 32'd12, 8'd0, 3'd2, 2'd1);
    tick(); tick();
    beat("postrst_b0", 32'h44, 2'd0, 1'b1, 4'd10);
    tick();
    do_rack();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
